// File: rtl/xmem_loader.sv
// DMA-style loader: reads len words from an external word-addressed bus
// (base + i*stride) and writes them to consecutive memory addresses.
module xmem_loader #(
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int EXT_ADDR_W = 32,
  parameter int STRIDE_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [EXT_ADDR_W-1:0] ext_base,
  input  logic [STRIDE_W-1:0]   ext_stride,
  input  logic [MEM_ADDR_W-1:0] mem_base,
  input  logic [MEM_ADDR_W:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [MEM_ADDR_W:0]   words_done,
  output logic                  ext_valid,
  output logic [EXT_ADDR_W-1:0] ext_addr,
  input  logic                  ext_ready,
  input  logic                  ext_rvalid,
  input  logic [DATA_W-1:0]     ext_rdata,
  output logic                  mem_valid,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata
);

  typedef enum logic [2:0] {IDLE, REQ, RESP, WR, DONE} state_t;

  localparam logic [MEM_ADDR_W:0]   WD_ONE  = 1;
  localparam logic [MEM_ADDR_W-1:0] MA_ONE  = 1;

  state_t                state, state_nxt;
  logic [MEM_ADDR_W:0]   len_q;
  logic [STRIDE_W-1:0]   stride_q;
  logic                  abort_q;
  logic                  last;

  // An abort seen during the write itself also ends the transfer after this word.
  assign last = ((words_done + WD_ONE) == len_q) || abort_q || abort;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DONE : REQ;
      REQ:     if (ext_ready) state_nxt = RESP;
      RESP:    if (ext_rvalid) state_nxt = WR;
      WR:      state_nxt = last ? DONE : REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are flops decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      ext_valid  <= 1'b0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      words_done <= '0;
      ext_addr   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      len_q      <= '0;
      stride_q   <= '0;
      abort_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt == REQ) || (state_nxt == RESP) || (state_nxt == WR);
      done      <= (state_nxt == DONE);
      ext_valid <= (state_nxt == REQ);
      mem_valid <= (state_nxt == WR);
      mem_we    <= (state_nxt == WR);
      case (state)
        IDLE: begin
          abort_q <= 1'b0;
          if (start) begin
            len_q      <= len;
            stride_q   <= ext_stride;
            ext_addr   <= ext_base;
            mem_addr   <= mem_base;
            words_done <= '0;
          end
        end
        REQ: if (abort) abort_q <= 1'b1;
        RESP: begin
          if (abort) abort_q <= 1'b1;
          if (ext_rvalid) mem_wdata <= ext_rdata;
        end
        WR: begin
          if (abort) abort_q <= 1'b1;
          words_done <= words_done + WD_ONE;
          ext_addr   <= ext_addr + EXT_ADDR_W'(stride_q);
          mem_addr   <= mem_addr + MA_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xmem_loader.sv
// Scoreboard bench for xmem_loader: stimulus pushes expected requests, writes
// and completions; a negedge monitor pops and compares.
module tb_xmem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [31:0] ext_base;
  logic [15:0] ext_stride;
  logic [9:0]  mem_base;
  logic [10:0] len;
  logic        busy, done;
  logic [10:0] words_done;
  logic        ext_valid;
  logic [31:0] ext_addr;
  logic        ext_ready, ext_rvalid;
  logic [31:0] ext_rdata;
  logic        mem_valid, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;

  xmem_loader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .ext_base(ext_base), .ext_stride(ext_stride), .mem_base(mem_base), .len(len),
    .busy(busy), .done(done), .words_done(words_done),
    .ext_valid(ext_valid), .ext_addr(ext_addr), .ext_ready(ext_ready),
    .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0, last_wr = 0, wr_cnt = 0;
  int cfg_rdy = 0, cfg_rv = 0, cfg_spur = 0, chk_gap = 0;

  logic [31:0] exp_ext[$];
  logic [9:0]  exp_wa[$];
  logic [31:0] exp_wd[$];
  logic [10:0] exp_done[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [63:0] got);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %0h with nothing expected", nm, got);
  endtask

  // External bus responder: ready after cfg_rdy stall cycles, rdata = address
  // returned cfg_rv cycles after the accept cycle.
  initial begin
    logic [31:0] rd;
    int rv_cnt, rdy_cnt;
    bit rv_pend;
    rd = '0; rv_cnt = 0; rdy_cnt = 0; rv_pend = 0;
    ext_ready = 1'b0; ext_rvalid = 1'b0; ext_rdata = '0;
    forever begin
      @(posedge clk); #2;
      ext_rvalid = 1'b0;
      ext_ready  = 1'b0;
      if (!rst) begin
        rv_pend = 0;
        rdy_cnt = cfg_rdy;
      end else begin
        if (rv_pend) begin
          if (rv_cnt == 0) begin
            ext_rvalid = 1'b1; ext_rdata = rd; rv_pend = 0;
          end else rv_cnt--;
        end
        if (ext_valid) begin
          if (rdy_cnt == 0) begin
            ext_ready = 1'b1; rv_pend = 1; rv_cnt = cfg_rv; rd = ext_addr; rdy_cnt = cfg_rdy;
          end else begin
            rdy_cnt--;
            if (cfg_spur != 0) begin
              ext_rvalid = 1'b1; ext_rdata = 32'hDEAD_BEEF;
            end
          end
        end else rdy_cnt = cfg_rdy;
      end
    end
  end

  // Monitor / scoreboard
  logic        prev_valid = 1'b0, prev_hs = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_outputs", {busy, done, words_done, ext_valid, ext_addr, mem_valid,
                            mem_we, mem_addr, mem_wdata}, '0);
      prev_valid = 1'b0;
    end else begin
      if (ext_valid && ext_ready) begin
        if (exp_ext.size() == 0) unexpected("extra_request", ext_addr);
        else chk("ext_addr", ext_addr, exp_ext.pop_front());
      end
      if (ext_valid && prev_valid && !prev_hs) chk("ext_addr_stable", ext_addr, prev_addr);
      prev_valid = ext_valid;
      prev_hs    = ext_valid && ext_ready;
      prev_addr  = ext_addr;
      if (mem_valid) begin
        chk("mem_we", mem_we, 1);
        chk("busy_in_write", busy, 1);
        if (exp_wa.size() == 0) unexpected("extra_write", {mem_addr, mem_wdata});
        else begin
          chk("mem_addr", mem_addr, exp_wa.pop_front());
          chk("mem_wdata", mem_wdata, exp_wd.pop_front());
        end
        if (chk_gap != 0 && last_wr > start_cyc) chk("write_spacing", cyc - last_wr, 3);
        last_wr = cyc;
        wr_cnt++;
      end
      if (done) begin
        chk("busy_at_done", busy, 0);
        if (exp_done.size() == 0) unexpected("extra_done", words_done);
        else begin
          logic [10:0] w;
          w = exp_done.pop_front();
          chk("words_done", words_done, w);
          if (w != 0) chk("done_after_last_write", cyc, last_wr + 1);
          else        chk("done_zero_len", cyc, start_cyc + 1);
        end
      end
    end
  end

  task automatic push_wr(input logic [9:0] a, input logic [31:0] d);
    exp_wa.push_back(a);
    exp_wd.push_back(d);
  endtask

  task automatic run(input logic [31:0] eb, input logic [15:0] st,
                     input logic [9:0] mb, input logic [10:0] ln);
    @(posedge clk); #2;
    ext_base = eb; ext_stride = st; mem_base = mb; len = ln;
    start = 1'b1; start_cyc = cyc;
    @(posedge clk); #2;
    // config changes after launch must not leak into the transfer
    start = 1'b0; ext_base = 32'hA5A5_0000; ext_stride = 16'h77; mem_base = 10'h155; len = 11'd3;
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (exp_ext.size() == 0) && (exp_wa.size() == 0) && (exp_done.size() == 0) && !busy;
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_timeout: pending req/wr/done %0d/%0d/%0d expected 0/0/0",
               nm, exp_ext.size(), exp_wa.size(), exp_done.size());
    end
    repeat (10) @(posedge clk);
  endtask

  initial begin
    int w0;
    bit found;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    ext_base = '0; ext_stride = '0; mem_base = '0; len = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Basic transfer
    chk_gap = 1;
    for (int i = 0; i < 4; i++) exp_ext.push_back(32'h100 + i);
    push_wr(10'h000, 32'h100); push_wr(10'h001, 32'h101);
    push_wr(10'h002, 32'h102); push_wr(10'h003, 32'h103);
    exp_done.push_back(11'd4);
    run(32'h100, 16'd1, 10'h000, 11'd4);
    wait_idle("basic");

    // Stride and wrap
    exp_ext.push_back(32'hFFFF_FFFE); exp_ext.push_back(32'h1); exp_ext.push_back(32'h4);
    push_wr(10'h3FE, 32'hFFFF_FFFE); push_wr(10'h3FF, 32'h1); push_wr(10'h000, 32'h4);
    exp_done.push_back(11'd3);
    run(32'hFFFF_FFFE, 16'd3, 10'h3FE, 11'd3);
    wait_idle("wrap");
    chk_gap = 0;

    // Backpressure with spurious rvalid while stalled in REQ
    cfg_rdy = 5; cfg_rv = 7; cfg_spur = 1;
    exp_ext.push_back(32'h2000); exp_ext.push_back(32'h2010);
    push_wr(10'h010, 32'h2000); push_wr(10'h011, 32'h2010);
    exp_done.push_back(11'd2);
    run(32'h2000, 16'h10, 10'h010, 11'd2);
    wait_idle("backpressure");
    cfg_rdy = 0; cfg_rv = 0; cfg_spur = 0;

    // Zero length
    exp_done.push_back(11'd0);
    run(32'h3000, 16'd1, 10'h020, 11'd0);
    wait_idle("zero_len");

    // Abort while word 2 waits for its response; start while busy is ignored
    cfg_rv = 2;
    exp_ext.push_back(32'h500); exp_ext.push_back(32'h502); exp_ext.push_back(32'h504);
    push_wr(10'h040, 32'h500); push_wr(10'h041, 32'h502); push_wr(10'h042, 32'h504);
    exp_done.push_back(11'd3);
    w0 = wr_cnt;
    run(32'h500, 16'd2, 10'h040, 11'd8);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); #1;
      found = (wr_cnt == w0 + 2);
    end
    if (found) begin
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
        @(negedge clk); #1;
        found = ext_valid && ext_ready;
      end
    end
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL abort_setup: word 2 request not seen, writes %0d expected %0d", wr_cnt - w0, 2);
    end
    @(posedge clk); #2 abort = 1'b1;
    @(posedge clk); #2 abort = 1'b0; start = 1'b1; len = 11'd1; ext_base = 32'h9000;
    @(posedge clk); #2 start = 1'b0;
    wait_idle("abort");
    repeat (20) @(posedge clk);
    cfg_rv = 0;

    // Reset during the write of word 1
    exp_ext.push_back(32'h700); exp_ext.push_back(32'h701);
    push_wr(10'h080, 32'h700);
    run(32'h700, 16'd1, 10'h080, 11'd4);
    w0 = 0;
    for (int i = 0; i < 100 && w0 < 2; i++) begin
      @(posedge clk); #2;
      if (mem_valid) w0++;
      if (w0 == 2) rst = 1'b0;
    end
    n_chk++;
    if (w0 != 2) begin
      n_fail++;
      $display("FAIL reset_setup: writes seen %0d expected 2", w0);
      rst = 1'b0;
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;

    exp_ext.push_back(32'h7777);
    push_wr(10'h003, 32'h7777);
    exp_done.push_back(11'd1);
    run(32'h7777, 16'd5, 10'h003, 11'd1);
    wait_idle("post_reset");

    chk("queues_drained", exp_ext.size() + exp_wa.size() + exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
